// File: rtl/pirdsp_alu_pkg.sv
// Shared constants and FSM encoding for the SIMD ALU and its P-register stage.
package pirdsp_alu_pkg;

  localparam int SEG_W   = 18;
  localparam int NUM_SEG = 3;
  localparam int DATA_W  = SEG_W * NUM_SEG;

  localparam logic MODE_27X27   = 1'b0;
  localparam logic MODE_SUM_9X9 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/pirdsp_lane_ovf_detect.sv
// Maps the ALU's per-segment carry-outs to one overflow flag per lane.
module pirdsp_lane_ovf_detect
  import pirdsp_alu_pkg::*;
(
  input  logic [2*NUM_SEG-1:0] carry_i,
  input  logic                 use_simd_i,
  output logic [NUM_SEG-1:0]   flag_o
);

  logic [NUM_SEG-1:0] seg_any;

  for (genvar i = 0; i < NUM_SEG; i++) begin : g_seg
    assign seg_any[i] = |carry_i[2*i +: 2];
  end

  // In full-width mode the lower segment carries ripple inside the ALU.
  assign flag_o = (use_simd_i == MODE_SUM_9X9) ? seg_any
                                               : {seg_any[NUM_SEG-1], {(NUM_SEG-1){1'b0}}};

endmodule

// File: rtl/pirdsp_accum_p_stage.sv
// P-register accumulator stage behind the three-segment SIMD ALU.
// Build option PIRDSP_ACC_SATURATE_EN: overflowing lanes load all-ones instead of wrapping.
//
// state | meaning
// IDLE  | waiting for the first beat of an accumulation
// ACCUM | mid-accumulation, P fed back to the ALU W operand
// HOLD  | completed result presented downstream
module pirdsp_accum_p_stage
  import pirdsp_alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              USE_SIMD,
  input  logic [CNT_W-1:0]  acc_len,
  input  logic [DATA_W-1:0] S,
  input  logic [5:0]        result_SIMD_carry_out,
  output logic [DATA_W-1:0] W_fb,
  output logic              use_simd_q,
  output logic [DATA_W-1:0] P,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        lane_ovf
);

  acc_state_e          state_q;
  logic [DATA_W-1:0]   p_q, p_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, len_q, len_d;
  logic [NUM_SEG-1:0]  ovf_q, flags;
  logic                out_valid_q;
  logic                accept, first_beat, mode_eff;

  assign in_ready   = (state_q != ST_HOLD) || out_ready;
  assign accept     = in_valid && in_ready;
  assign first_beat = accept && (state_q != ST_ACCUM);
  assign mode_eff   = first_beat ? USE_SIMD : use_simd_q;
  assign len_d      = (acc_len == '0) ? CNT_W'(1) : acc_len;
  assign cnt_d      = cnt_q + CNT_W'(1);

  assign W_fb      = (state_q == ST_ACCUM) ? p_q : '0;
  assign P         = p_q;
  assign out_valid = out_valid_q;
  assign lane_ovf  = ovf_q;

  pirdsp_lane_ovf_detect u_ovf (
    .carry_i    (result_SIMD_carry_out),
    .use_simd_i (mode_eff),
    .flag_o     (flags)
  );

  always_comb begin
    p_d = S;
`ifdef PIRDSP_ACC_SATURATE_EN
    if (mode_eff == MODE_SUM_9X9) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        if (flags[i]) p_d[i*SEG_W +: SEG_W] = '1;
      end
    end else if (flags[NUM_SEG-1]) begin
      p_d = '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      p_q         <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      use_simd_q  <= MODE_27X27;
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (first_beat) begin
            use_simd_q <= USE_SIMD;
            len_q      <= len_d;
            p_q        <= p_d;
            cnt_q      <= CNT_W'(1);
            ovf_q      <= flags;
            if (len_d == CNT_W'(1)) begin
              state_q     <= ST_HOLD;
              out_valid_q <= 1'b1;
            end else begin
              state_q     <= ST_ACCUM;
              out_valid_q <= 1'b0;
            end
          end else if (state_q == ST_HOLD && out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            p_q   <= p_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_q | flags;
            if (cnt_d == len_q) begin
              state_q     <= ST_HOLD;
              out_valid_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pirdsp_accum_p_stage.md
Name: pirdsp_accum_p_stage

Overview:
- Result/accumulator register stage directly downstream of the 54-bit three-segment SIMD ALU.
- Captures the ALU sum S and its per-segment carry-outs into the P register.
- Feeds P back to the ALU W operand to run multi-beat accumulations, and returns the latched SIMD mode to the ALU.
- Presents the finished accumulation downstream with a valid/ready handshake and sticky per-lane overflow flags.

Parameters:
- DATA_W, 54, P/S width; fixed at 3 x SEG_W.
- SEG_W, 18, ALU segment width; one SIMD lane per segment.
- CNT_W, 8, width of the accumulation-length input and beat counter.

Ports:
- clk  in  1  Single clock.
- reset  in  1  Synchronous active-high reset.
- in_valid  in  1  ALU result (S, carries) valid this cycle.
- in_ready  out  1  Stage accepts the beat this cycle.
- USE_SIMD  in  1  Requested mode: 0 = 27x27 full width, 1 = sum of 9x9 (three independent lanes).
- acc_len  in  CNT_W  Beats per accumulation; sampled on the first beat.
- S  in  DATA_W  ALU sum.
- result_SIMD_carry_out  in  6  ALU carry-outs, 2 bits per segment.
- W_fb  out  DATA_W  Feedback to ALU W operand.
- use_simd_q  out  1  Latched mode; drives ALU USE_SIMD.
- P  out  DATA_W  Accumulated result.
- out_valid  out  1  P holds a completed accumulation.
- out_ready  in  1  Downstream consumes P.
- lane_ovf  out  3  Sticky per-lane overflow.

Behaviour:
- Reset: all values below are forced by reset. A reset mid-accumulation discards the partial result.
  - state = IDLE
  - P = 0, cnt = 0, len_q = 0
  - out_valid = 0, lane_ovf = 0
  - use_simd_q = 0
- FSM states and transitions:
  - IDLE: waiting for the first beat of an accumulation.
  - ACCUM: mid-accumulation.
  - HOLD: completed result presented downstream.
  - "accept" = in_valid && in_ready.
  - in_ready = (state != HOLD) || out_ready.
- W_fb:
  - Equals P in ACCUM.
  - Equals 0 in IDLE and HOLD, so the next beat starts a fresh sum.
  - Purely combinational from state and P.
- First beat (accept in IDLE, or accept in HOLD with out_ready):
  - use_simd_q <= USE_SIMD.
  - len_q <= max(acc_len, 1).
  - P <= S; cnt <= 1; lane_ovf <= carry flags of this beat.
  - If the effective length is 1, go to HOLD; else go to ACCUM.
- Accept in ACCUM:
  - P <= S; cnt <= cnt + 1; lane_ovf |= carry flags.
  - When cnt + 1 == len_q, go to HOLD.
- No accept: registers hold their values.
- USE_SIMD changes after the first beat are ignored until the next first beat.
- out_valid is 1 exactly in HOLD, with a latency of 1 cycle after the final accepted beat.
- HOLD with out_ready = 1 and no accept: go to IDLE.
- HOLD with out_ready = 1 and an accept in the same cycle: treat as a first beat. There are no bubbles between back-to-back accumulations.
- Carry flags:
  - SIMD mode: flag[i] = |result_SIMD_carry_out[2i+1:2i], for i = 0..2.
  - Full mode: flag[2] = |result_SIMD_carry_out[5:4]; flag[1:0] = 0. Inter-segment carries are internal to the ALU.
- Arithmetic wraps modulo 2^SEG_W per lane (SIMD) or 2^DATA_W (full). No sign handling.

Optional Feature:
- Macro: PIRDSP_ACC_SATURATE_EN.
- Defined: on any accept where a lane flag is set, that lane of P loads all-ones instead of S.
  - SIMD: the 18-bit lane only.
  - Full mode: all 54 bits.
  - lane_ovf is still set.
- Undefined: P always loads S (wrap). lane_ovf alone reports overflow.

Decomposition:
- Shared package pirdsp_alu_pkg holds:
  - SEG_W, NUM_SEG = 3, DATA_W.
  - Mode constants MODE_27X27 = 0, MODE_SUM_9X9 = 1.
  - FSM state encoding.
- One natural sub-module: pirdsp_lane_ovf_detect. It maps the 6 carry bits plus mode to 3 lane flags and is reusable by the ALU-side checker.

Test Plan:
- Full mode, acc_len = 3, S beats 0x10, 0x20, 0x30, no carries -> out_valid rises 1 cycle after the 3rd beat; P = 0x30; W_fb = 0 on beat 1 and P afterwards; lane_ovf = 000.
- SIMD mode, acc_len = 2, carry_out = 6'b00_01_00 on beat 2 -> lane_ovf = 3'b010. With PIRDSP_ACC_SATURATE_EN, P[35:18] = 0x3FFFF and the other lanes are unchanged.
- Full mode, carry_out = 6'b00_11_00 -> lane_ovf = 000, because only segment 2 counts in full mode.
- HOLD with out_ready = 0 for 4 cycles -> in_ready = 0 and P stable. Then out_ready = 1 with in_valid = 1 -> new accumulation starts the same cycle with W_fb = 0 and no idle cycle.
- acc_len = 0 -> behaves as length 1; out_valid after one beat. USE_SIMD toggled mid-accumulation -> use_simd_q unchanged.
- Reset asserted during ACCUM (cnt = 2) -> next cycle state IDLE, P = 0, out_valid = 0, lane_ovf = 0.
